count_uart_tx: RTL and testbench

//  Downstream consumer of the 8-bit free-running counter. Captures the count

---
 rtl/count_uart_tx_pkg.sv | 15 +
 rtl/count_uart_tx_fifo.sv | 48 ++++
 rtl/count_uart_tx.sv | 143 ++++++++++++++
 tb/tb_count_uart_tx.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_uart_tx_pkg.sv
// rtl/count_uart_tx_pkg.sv - shared types and constants for the count UART transmitter
package count_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam logic UART_IDLE_LVL  = 1'b1;
  localparam logic UART_START_LVL = 1'b0;
  localparam int   DATA_BITS      = 8;

endpackage

// File: rtl/count_uart_tx_fifo.sv
// rtl/count_uart_tx_fifo.sv - single-clock first-word fall-through capture FIFO
module count_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;
  logic             do_pop;
  logic             do_push;

  // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rdata   = mem_q[rptr_q[AW-1:0]];

  // Pointer update; extra MSB distinguishes full from empty
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PTR_ONE;
      if (do_pop)  rptr_q <= rptr_q + PTR_ONE;
    end
  end

  // Storage write, no reset needed on the data array
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/count_uart_tx.sv
// rtl/count_uart_tx.sv - captures counter values on sample edges and sends them as 8N1 frames
module count_uart_tx
  import count_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] count_in,
  input  logic       sample_req,
  input  logic       ovf_clr,
  output logic       tx,
  output logic       busy,
  output logic       fifo_full,
  output logic       overflow
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);

  uart_state_e       state_q;
  logic [BAUD_W-1:0] baud_q;
  logic [2:0]        bit_idx_q;
  logic [7:0]        shreg_q;
  logic              tx_q;
  logic              busy_q;
  logic              req_q;
  logic              ovf_q;
  logic              ovf_d;

  logic              capture;
  logic              baud_end;
  logic              pop;
  logic              drop;
  logic              fifo_empty;
  logic [7:0]        fifo_rdata;

  assign capture  = sample_req && !req_q;
  assign baud_end = (baud_q == BAUD_LAST);
  assign pop      = !fifo_empty && ((state_q == IDLE) || ((state_q == STOP) && baud_end));
  assign drop     = capture && fifo_full && !pop;

  count_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (capture),
    .pop   (pop),
    .wdata (count_in),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Sticky overflow: a drop in the same cycle beats a clear
  always_comb begin
    ovf_d = ovf_q;
    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  // Edge-detect history and overflow flag; history resets high so a held level is ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q <= 1'b1;
      ovf_q <= 1'b0;
    end else begin
      req_q <= sample_req;
      ovf_q <= ovf_d;
    end
  end

  // Frame FSM with baud counter; tx/busy are registered from the current state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      tx_q      <= UART_IDLE_LVL;
      busy_q    <= 1'b0;
    end else begin
      busy_q <= (state_q != IDLE);
      case (state_q)
        IDLE: begin
          tx_q   <= UART_IDLE_LVL;
          baud_q <= '0;
          if (pop) begin
            shreg_q   <= fifo_rdata;
            bit_idx_q <= '0;
            state_q   <= START;
          end
        end
        START: begin
          tx_q <= UART_START_LVL;
          if (baud_end) begin
            baud_q  <= '0;
            state_q <= DATA;
          end else begin
            baud_q <= baud_q + BAUD_ONE;
          end
        end
        DATA: begin
          tx_q <= shreg_q[0];
          if (baud_end) begin
            baud_q    <= '0;
            shreg_q   <= {1'b0, shreg_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == BIT_LAST) state_q <= STOP;
          end else begin
            baud_q <= baud_q + BAUD_ONE;
          end
        end
        STOP: begin
          tx_q <= UART_IDLE_LVL;
          if (baud_end) begin
            baud_q <= '0;
            if (pop) begin
              shreg_q   <= fifo_rdata;
              bit_idx_q <= '0;
              state_q   <= START;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            baud_q <= baud_q + BAUD_ONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_count_uart_tx.sv
// tb/tb_count_uart_tx.sv - randomized and directed bench for count_uart_tx
module tb_count_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] count_in = 8'h00;
  logic       sample_req = 1'b1;
  logic       ovf_clr = 1'b0;
  logic       tx;
  logic       busy;
  logic       fifo_full;
  logic       overflow;

  int nchecks = 0;
  int nerr    = 0;

  always #5 clk = ~clk;

  count_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .count_in   (count_in),
    .sample_req (sample_req),
    .ovf_clr    (ovf_clr),
    .tx         (tx),
    .busy       (busy),
    .fifo_full  (fifo_full),
    .overflow   (overflow)
  );

  // Reference model: a byte queue plus a timeline of when frames leave the line
  logic [7:0] mq[$];
  logic       m_req_prev = 1'b1;
  logic       m_ovf = 1'b0;
  int         cyc = 0;
  int         m_next_pop = 0;
  int         m_pop_edge = -100000;
  int         m_prev_pop_edge = -100000;
  logic [7:0] m_byte = 8'h00;
  logic [7:0] m_prev_byte = 8'h00;

  function automatic logic frame_bit(logic [7:0] b, int k);
    if (k < CPB) return 1'b0;
    if (k >= 9 * CPB) return 1'b1;
    return b[k / CPB - 1];
  endfunction

  // Expected {tx, busy, fifo_full, overflow} after the most recent edge
  function automatic logic [3:0] exp_vec();
    int   k  = cyc - m_pop_edge - 1;
    int   kp = cyc - m_prev_pop_edge - 1;
    logic t  = 1'b1;
    logic bz = 1'b0;
    logic f  = (mq.size() == DEPTH);
    if (k >= 0 && k < FRAME) begin
      t  = frame_bit(m_byte, k);
      bz = 1'b1;
    end else if (kp >= 0 && kp < FRAME) begin
      t  = frame_bit(m_prev_byte, kp);
      bz = 1'b1;
    end
    return {t, bz, f, m_ovf};
  endfunction

  // Advance one clock, update the model from the inputs seen at that edge
  task automatic step();
    bit cap;
    bit pop;
    bit drop;
    @(posedge clk);
    cyc++;
    if (rst) begin
      mq.delete();
      m_req_prev      = 1'b1;
      m_ovf           = 1'b0;
      m_pop_edge      = -100000;
      m_prev_pop_edge = -100000;
      m_next_pop      = cyc + 1;
    end else begin
      cap        = sample_req && !m_req_prev;
      m_req_prev = sample_req;
      pop        = (mq.size() > 0) && (cyc >= m_next_pop);
      drop       = cap && (mq.size() == DEPTH) && !pop;
      if (drop) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
      if (pop) begin
        m_prev_pop_edge = m_pop_edge;
        m_prev_byte     = m_byte;
        m_byte          = mq.pop_front();
        m_pop_edge      = cyc;
        m_next_pop      = cyc + FRAME;
      end
      if (cap && !drop) mq.push_back(count_in);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sample_req = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    nchecks++;
    if ({tx, busy, fifo_full, overflow} !== 4'b1000) begin
      nerr++;
      $display("FAIL reset_state got=%b exp=1000", {tx, busy, fifo_full, overflow});
    end
    for (int i = 0; i < 100; i++) begin
      step();
      nchecks++;
      if ({tx, busy, overflow} !== 3'b100) begin
        nerr++;
        $display("FAIL reset_held_req cyc=%0d got=%b exp=100", cyc, {tx, busy, overflow});
      end
    end
    sample_req = 1'b0;
    step();
  endtask

  task automatic test_single_frame();
    logic [9:0] bits = 10'b1101001010;
    int busy_cnt = 0;
    count_in = 8'hA5;
    sample_req = 1'b1;
    step();
    sample_req = 1'b0;
    count_in = 8'h5A;
    step();
    nchecks++;
    if (tx !== 1'b1) begin
      nerr++;
      $display("FAIL latency_n1 got tx=%b exp=1", tx);
    end
    step();
    for (int i = 0; i < FRAME; i++) begin
      if (busy === 1'b1) busy_cnt++;
      nchecks++;
      if ({tx, busy} !== {bits[i / CPB], 1'b1} || {tx, busy, fifo_full, overflow} !== exp_vec()) begin
        nerr++;
        $display("FAIL frame_a5 i=%0d got=%b exp_bit=%b model=%b", i, {tx, busy, fifo_full, overflow},
                 bits[i / CPB], exp_vec());
      end
      count_in = 8'($urandom);
      step();
    end
    nchecks++;
    if ({tx, busy} !== 2'b10 || busy_cnt != FRAME) begin
      nerr++;
      $display("FAIL frame_end got tx/busy=%b busy_cycles=%0d exp 10 and %0d", {tx, busy}, busy_cnt, FRAME);
    end
  endtask

  task automatic test_burst();
    int busy_cnt = 0;
    int rises = 0;
    logic prev_busy = 1'b0;
    for (int c = 0; c < 12 + 250; c++) begin
      sample_req = (c < 12) && (c % 2 == 0);
      count_in   = (c < 12) ? 8'(c / 2 + 1) : 8'($urandom);
      step();
      if (busy === 1'b1) busy_cnt++;
      if (busy === 1'b1 && prev_busy === 1'b0) rises++;
      prev_busy = busy;
      nchecks++;
      if ({tx, busy, fifo_full, overflow} !== exp_vec()) begin
        nerr++;
        $display("FAIL burst cyc=%0d got=%b exp=%b", cyc, {tx, busy, fifo_full, overflow}, exp_vec());
      end
    end
    nchecks++;
    if (busy_cnt != 5 * FRAME || rises != 1 || overflow !== 1'b1) begin
      nerr++;
      $display("FAIL burst_summary busy_cycles=%0d rises=%0d ovf=%b exp %0d 1 1",
               busy_cnt, rises, overflow, 5 * FRAME);
    end
  endtask

  task automatic test_ovf_clr();
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    nchecks++;
    if (overflow !== 1'b0) begin
      nerr++;
      $display("FAIL ovf_clear_first got=%b exp=0", overflow);
    end
    for (int c = 0; c < 12; c++) begin
      sample_req = (c % 2 == 0);
      count_in   = 8'h20 + 8'(c / 2);
      ovf_clr    = (c == 10);
      step();
      nchecks++;
      if ({tx, busy, fifo_full, overflow} !== exp_vec()) begin
        nerr++;
        $display("FAIL ovf_seq cyc=%0d got=%b exp=%b", cyc, {tx, busy, fifo_full, overflow}, exp_vec());
      end
    end
    sample_req = 1'b0;
    nchecks++;
    if (overflow !== 1'b1) begin
      nerr++;
      $display("FAIL ovf_drop_wins got=%b exp=1", overflow);
    end
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    nchecks++;
    if (overflow !== 1'b0) begin
      nerr++;
      $display("FAIL ovf_clear_again got=%b exp=0", overflow);
    end
    for (int c = 0; c < 5 * FRAME + 10; c++) begin
      step();
      nchecks++;
      if ({tx, busy, fifo_full, overflow} !== exp_vec()) begin
        nerr++;
        $display("FAIL ovf_drain cyc=%0d got=%b exp=%b", cyc, {tx, busy, fifo_full, overflow}, exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    for (int c = 0; c < 20; c++) begin
      sample_req = (c == 0) || (c == 2);
      count_in   = (c == 0) ? 8'h3C : 8'h77;
      rst        = (c == 19);
      if (c == 19) begin
        nchecks++;
        if (busy !== 1'b1) begin
          nerr++;
          $display("FAIL pre_reset_busy got=%b exp=1", busy);
        end
      end
      step();
    end
    rst = 1'b0;
    sample_req = 1'b0;
    nchecks++;
    if ({tx, busy, fifo_full, overflow} !== 4'b1000 || exp_vec() !== 4'b1000) begin
      nerr++;
      $display("FAIL reset_mid_frame got=%b exp=1000", {tx, busy, fifo_full, overflow});
    end
    for (int c = 0; c < 100; c++) begin
      step();
      nchecks++;
      if ({tx, busy} !== 2'b10) begin
        nerr++;
        $display("FAIL post_reset_quiet cyc=%0d got=%b exp=10", cyc, {tx, busy});
      end
    end
  endtask

  task automatic test_full_push_pop();
    int guard = 0;
    for (int c = 0; c < 10; c++) begin
      sample_req = (c % 2 == 0);
      count_in   = 8'h40 + 8'(c / 2);
      step();
    end
    sample_req = 1'b0;
    while (cyc + 1 != m_next_pop && guard < 100) begin
      step();
      guard++;
    end
    nchecks++;
    if (guard >= 100 || fifo_full !== 1'b1) begin
      nerr++;
      $display("FAIL full_setup guard=%0d fifo_full=%b exp full=1", guard, fifo_full);
    end
    sample_req = 1'b1;
    count_in   = 8'h45;
    step();
    sample_req = 1'b0;
    nchecks++;
    if ({fifo_full, overflow} !== 2'b10) begin
      nerr++;
      $display("FAIL full_push_pop got full/ovf=%b exp=10", {fifo_full, overflow});
    end
    for (int c = 0; c < 5 * FRAME + 10; c++) begin
      step();
      nchecks++;
      if ({tx, busy, fifo_full, overflow} !== exp_vec()) begin
        nerr++;
        $display("FAIL full_drain cyc=%0d got=%b exp=%b", cyc, {tx, busy, fifo_full, overflow}, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600 + 6 * FRAME; c++) begin
      sample_req = (c < 600) ? 1'($urandom_range(0, 1)) : 1'b0;
      count_in   = 8'($urandom);
      ovf_clr    = ($urandom_range(0, 15) == 0);
      step();
      nchecks++;
      if ({tx, busy, fifo_full, overflow} !== exp_vec()) begin
        nerr++;
        $display("FAIL random cyc=%0d got=%b exp=%b", cyc, {tx, busy, fifo_full, overflow}, exp_vec());
      end
    end
    ovf_clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_burst();
    test_ovf_clr();
    test_reset_mid_frame();
    test_full_push_pop();
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
